pmem_line_responder: RTL and testbench
======================================

Name: pmem_line_responder

Overview:
- Synthesizable memory-side responder for the 128-bit line physical-memory interface that the mp3 core drives: pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_resp, pmem_rdata.
- Backs each 128-bit line with a 32-bit-wide word array, accessed one word per cycle.
- A read assembles 4 beats into pmem_rdata; a write splits pmem_wdata into 4 word stores.
- Programmable access delay models DRAM latency. Drop-in synthesizable alternative to the behavioural DRAM model on the mp3 top level.

Parameters:
- ADDR_WIDTH, 16, byte address width of pmem_address.
- LINE_WIDTH, 128, line width in bits.
- WORD_WIDTH, 32, backing-array word width. LINE_WIDTH/WORD_WIDTH = BEATS = 4.
- DEPTH_LINES, 256, number of lines stored. Power of 2.
- ACCESS_DELAY, 3, wait cycles before the first beat. 0 is legal.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- pmem_read  in  1  read request, level, held by initiator until resp.
- pmem_write  in  1  write request, level, held by initiator until resp.
- pmem_address  in  ADDR_WIDTH  byte address; bits [3:0] ignored (line-aligned).
- pmem_wdata  in  LINE_WIDTH  write line; word k = bits [32k+31:32k].
- pmem_resp  out  1  one-cycle completion pulse.
- pmem_rdata  out  LINE_WIDTH  read line, valid while pmem_resp=1.
- busy  out  1  high from accept through the resp cycle.
- req_error  out  1  one-cycle pulse on an illegal request (read and write both high).

Behaviour:
- Reset (async): state=IDLE, pmem_resp=0, pmem_rdata=0, busy=0, req_error=0, counters=0. The storage array is not reset.
- Line index = pmem_address[ADDR_WIDTH-1:4] modulo DEPTH_LINES; upper bits alias silently.
- States: IDLE, WAIT, READ_BEATS, WRITE_BEATS, RESP.
- IDLE, read XOR write high at cycle 0:
  - Latch index, op and wdata; busy=1.
  - Go to WAIT, or straight to beats if ACCESS_DELAY=0.
- WAIT: exactly ACCESS_DELAY cycles (cycles 1..D), delay counter counts down.
- READ_BEATS: cycles D+1..D+4, beat k reads word k of the line into rdata slice k; beat counter wraps 3→0 and exits.
- WRITE_BEATS: cycles D+1..D+4, beat k stores latched wdata slice k.
- RESP: cycle D+5, pmem_resp=1 for exactly one cycle; pmem_rdata holds the assembled line (read) or is unchanged (write); busy=1. Next state is IDLE.
- Total: resp asserted D+5 cycles after the accept edge; D=0 gives resp 5 cycles after accept.
- pmem_rdata holds its value after RESP until the next read's RESP cycle.
- Initiator must deassert in the cycle after resp. A request still high in IDLE is accepted as a new back-to-back request (no dead cycle).
- Inputs are ignored while busy. Address/wdata changes after accept have no effect. Deasserting the request mid-operation does not abort; resp still pulses.
- read=1 and write=1 together in IDLE: no access, no resp, req_error=1 for one cycle, stay IDLE; re-evaluated every cycle.
- Reset mid-operation: abort immediately, no resp. On a write, words already stored persist; remaining words are unchanged.

Test Plan:
- Write 0x00112233_44556677_8899AABB_CCDDEEFF to address 0x0040, then read 0x0040 → resp at accept+8 (D=3); rdata equals the written line; busy high 9 cycles.
- ACCESS_DELAY=0: read → resp exactly 5 cycles after accept; back-to-back write then read with requests held at resp → both complete, no dead cycle between them.
- Address aliasing: write line A to 0x0010, read 0x1010 (DEPTH_LINES=256) → returns line A; read 0x001F → returns line A (low bits ignored).
- read=write=1 for 3 cycles → req_error pulses every cycle, no resp, busy=0; memory unchanged on a later read.
- During a write, change pmem_wdata and drop pmem_write at cycle 2 → resp still at D+5; stored line equals the value latched at accept.
- Assert rst during WRITE_BEATS after beat 1 → outputs zero immediately, no resp; later read shows words 0–1 new and words 2–3 old.

Source files
------------

// File: rtl/pmem_line_responder.sv
// Memory-side responder for the 128-bit line pmem interface: each line is kept as
// BEATS words and moved one word per cycle after a programmable access delay.
module pmem_line_responder #(
  parameter int ADDR_WIDTH   = 16,
  parameter int LINE_WIDTH   = 128,
  parameter int WORD_WIDTH   = 32,
  parameter int DEPTH_LINES  = 256,
  parameter int ACCESS_DELAY = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pmem_read,
  input  logic                  pmem_write,
  input  logic [ADDR_WIDTH-1:0] pmem_address,
  input  logic [LINE_WIDTH-1:0] pmem_wdata,
  output logic                  pmem_resp,
  output logic [LINE_WIDTH-1:0] pmem_rdata,
  output logic                  busy,
  output logic                  req_error
);

  localparam int BEATS = LINE_WIDTH / WORD_WIDTH;
  localparam int BW    = $clog2(BEATS);
  localparam int IW    = $clog2(DEPTH_LINES);
  localparam int OFS   = $clog2(LINE_WIDTH / 8);
  localparam int DW    = (ACCESS_DELAY > 0) ? $clog2(ACCESS_DELAY + 1) : 1;
  localparam logic [DW-1:0] DLY_LOAD = (ACCESS_DELAY > 0) ? DW'(ACCESS_DELAY - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_WAIT        = 3'd1,
    S_READ_BEATS  = 3'd2,
    S_WRITE_BEATS = 3'd3,
    S_RESP        = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic                    op_write_q, op_write_d;
  logic [LINE_WIDTH-1:0]   wdata_q, wdata_d;
  logic [LINE_WIDTH-1:0]   line_q, line_d;
  logic [LINE_WIDTH-1:0]   rdata_q, rdata_d;
  logic [DW-1:0]           delay_q, delay_d;
  logic [BW-1:0]           beat_q, beat_d;
  logic                    resp_q, resp_d;
  logic                    busy_q, busy_d;
  logic                    err_q, err_d;

  logic                    accept_s;
  logic                    mem_we_s;
  logic [IW+BW-1:0]        mem_addr_s;
  logic [WORD_WIDTH-1:0]   rd_word_s;
  logic [WORD_WIDTH-1:0]   wr_word_s;
  logic                    addr_unused_s;

  logic [WORD_WIDTH-1:0]   mem [DEPTH_LINES*BEATS];

  assign mem_addr_s    = {idx_q, beat_q};
  assign rd_word_s     = mem[mem_addr_s];
  assign wr_word_s     = wdata_q[beat_q*WORD_WIDTH +: WORD_WIDTH];
  // Only the line index bits select storage; offset and upper bits alias.
  assign addr_unused_s = ^pmem_address;

  // Next-state and datapath control.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    op_write_d = op_write_q;
    wdata_d    = wdata_q;
    line_d     = line_q;
    rdata_d    = rdata_q;
    delay_d    = delay_q;
    beat_d     = beat_q;
    resp_d     = 1'b0;
    err_d      = 1'b0;
    accept_s   = 1'b0;
    mem_we_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pmem_read ^ pmem_write) begin
          accept_s   = 1'b1;
          idx_d      = pmem_address[IW+OFS-1:OFS];
          op_write_d = pmem_write;
          wdata_d    = pmem_wdata;
          delay_d    = DLY_LOAD;
          beat_d     = '0;
          if (ACCESS_DELAY == 0) begin
            state_d = pmem_write ? S_WRITE_BEATS : S_READ_BEATS;
          end else begin
            state_d = S_WAIT;
          end
        end else if (pmem_read && pmem_write) begin
          err_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (delay_q == '0) begin
          state_d = op_write_q ? S_WRITE_BEATS : S_READ_BEATS;
        end else begin
          delay_d = delay_q - DW'(1);
        end
      end
      S_READ_BEATS: begin
        line_d[beat_q*WORD_WIDTH +: WORD_WIDTH] = rd_word_s;
        beat_d = beat_q + BW'(1);
        if (beat_q == BW'(BEATS - 1)) begin
          // Publish the whole line only at completion so pmem_rdata stays stable.
          rdata_d = line_d;
          resp_d  = 1'b1;
          state_d = S_RESP;
        end else begin
          state_d = S_READ_BEATS;
        end
      end
      S_WRITE_BEATS: begin
        mem_we_s = 1'b1;
        beat_d   = beat_q + BW'(1);
        if (beat_q == BW'(BEATS - 1)) begin
          resp_d  = 1'b1;
          state_d = S_RESP;
        end else begin
          state_d = S_WRITE_BEATS;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      op_write_q <= 1'b0;
      wdata_q    <= '0;
      line_q     <= '0;
      rdata_q    <= '0;
      delay_q    <= '0;
      beat_q     <= '0;
      resp_q     <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      op_write_q <= op_write_d;
      wdata_q    <= wdata_d;
      line_q     <= line_d;
      rdata_q    <= rdata_d;
      delay_q    <= delay_d;
      beat_q     <= beat_d;
      resp_q     <= resp_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  // Word store; the array is deliberately not reset so aborted writes keep stored beats.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem[mem_addr_s] <= wr_word_s;
    end
  end

  assign pmem_resp  = resp_q;
  assign pmem_rdata = rdata_q;
  // The accept cycle itself already counts as busy.
  assign busy       = busy_q | accept_s;
  assign req_error  = err_q;

endmodule

// File: tb/tb_pmem_line_responder.sv
// Directed bench for pmem_line_responder: unit 0 uses ACCESS_DELAY=3, unit 1 uses 0.
module tb_pmem_line_responder;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         rd_i    [2];
  logic         wr_i    [2];
  logic [15:0]  addr_i  [2];
  logic [127:0] wd_i    [2];
  logic         resp_o  [2];
  logic [127:0] rdata_o [2];
  logic         busy_o  [2];
  logic         err_o   [2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pmem_line_responder #(.ACCESS_DELAY(3)) u_dut_d3 (
    .clk(clk), .rst(rst), .pmem_read(rd_i[0]), .pmem_write(wr_i[0]),
    .pmem_address(addr_i[0]), .pmem_wdata(wd_i[0]), .pmem_resp(resp_o[0]),
    .pmem_rdata(rdata_o[0]), .busy(busy_o[0]), .req_error(err_o[0])
  );

  pmem_line_responder #(.ACCESS_DELAY(0)) u_dut_d0 (
    .clk(clk), .rst(rst), .pmem_read(rd_i[1]), .pmem_write(wr_i[1]),
    .pmem_address(addr_i[1]), .pmem_wdata(wd_i[1]), .pmem_resp(resp_o[1]),
    .pmem_rdata(rdata_o[1]), .busy(busy_o[1]), .req_error(err_o[1])
  );

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One complete transaction; optionally scrambles wdata and drops the request mid-flight.
  task automatic do_op(input int u, input bit wr_op, input logic [15:0] a,
                       input logic [127:0] d, input int dly, input bit perturb,
                       input string tag, output logic [127:0] rd);
    int rc;
    int bc;
    rd = '0;
    rc = -1;
    bc = 0;
    @(posedge clk); #1;
    rd_i[u] = !wr_op; wr_i[u] = wr_op; addr_i[u] = a; wd_i[u] = d;
    for (int n = 0; n < 40 && rc < 0; n++) begin
      @(negedge clk);
      if (busy_o[u]) bc++;
      if (resp_o[u]) begin
        rc = n;
        rd = rdata_o[u];
      end
      if (perturb && n == 1) begin
        wd_i[u] = ~d; wr_i[u] = 1'b0; rd_i[u] = 1'b0; addr_i[u] = a ^ 16'h0100;
      end
    end
    check_val({tag, "_latency"}, 128'(rc), 128'(dly + 5));
    check_val({tag, "_busy_cycles"}, 128'(bc), 128'(dly + 6));
    @(posedge clk); #1;
    rd_i[u] = 1'b0; wr_i[u] = 1'b0;
    @(negedge clk);
    check_val({tag, "_resp_width"}, 128'(resp_o[u]), 128'(0));
  endtask

  logic [127:0] la, lb, lc, ld, l_old, l_new, r, exp_mix;
  int           rc;
  int           bc;

  initial begin
    la    = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    lb    = 128'hDEADBEEF_01234567_89ABCDEF_FEEDFACE;
    lc    = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
    ld    = 128'h13579BDF_2468ACE0_11223344_55667788;
    l_old = 128'hAAAA0000_BBBB1111_CCCC2222_DDDD3333;
    l_new = 128'h11112222_33334444_55556666_77778888;
    exp_mix = {l_old[127:64], l_new[63:0]};
    for (int u = 0; u < 2; u++) begin
      rd_i[u] = 1'b0; wr_i[u] = 1'b0; addr_i[u] = 16'h0000; wd_i[u] = 128'h0;
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      check_val("rst_resp", 128'(resp_o[u]), 128'(0));
      check_val("rst_rdata", rdata_o[u], 128'h0);
      check_val("rst_busy", 128'(busy_o[u]), 128'(0));
      check_val("rst_err", 128'(err_o[u]), 128'(0));
    end
    rst = 1'b0;

    // Write then read at D=3
    do_op(0, 1'b1, 16'h0040, la, 3, 1'b0, "d3_wr", r);
    do_op(0, 1'b0, 16'h0040, 128'h0, 3, 1'b0, "d3_rd", r);
    check_val("d3_rd_data", r, la);

    // D=0: back-to-back write then read with requests held at resp
    @(posedge clk); #1;
    wr_i[1] = 1'b1; addr_i[1] = 16'h0200; wd_i[1] = lb;
    rc = -1;
    for (int n = 0; n < 40 && rc < 0; n++) begin
      @(negedge clk);
      if (resp_o[1]) rc = n;
    end
    check_val("b2b_wr_latency", 128'(rc), 128'(5));
    @(posedge clk); #1;
    wr_i[1] = 1'b0; rd_i[1] = 1'b1;
    rc = -1;
    bc = 0;
    r  = '0;
    for (int n = 0; n < 40 && rc < 0; n++) begin
      @(negedge clk);
      if (busy_o[1]) bc++;
      if (resp_o[1]) begin
        rc = n;
        r  = rdata_o[1];
      end
    end
    check_val("b2b_rd_latency", 128'(rc), 128'(5));
    check_val("b2b_rd_busy", 128'(bc), 128'(6));
    check_val("b2b_rd_data", r, lb);
    @(posedge clk); #1;
    rd_i[1] = 1'b0;
    do_op(1, 1'b0, 16'h0200, 128'h0, 0, 1'b0, "d0_rd", r);
    check_val("d0_rd_data", r, lb);

    // Address aliasing and ignored offset bits
    do_op(0, 1'b1, 16'h0010, lc, 3, 1'b0, "alias_wr", r);
    do_op(0, 1'b0, 16'h1010, 128'h0, 3, 1'b0, "alias_hi", r);
    check_val("alias_hi_data", r, lc);
    do_op(0, 1'b0, 16'h001F, 128'h0, 3, 1'b0, "alias_lo", r);
    check_val("alias_lo_data", r, lc);

    // Illegal read+write for three cycles
    @(posedge clk); #1;
    rd_i[0] = 1'b1; wr_i[0] = 1'b1; addr_i[0] = 16'h0040; wd_i[0] = ~la;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check_val("err_pulse", 128'(err_o[0]), 128'((n >= 1 && n <= 3) ? 1 : 0));
      check_val("err_resp", 128'(resp_o[0]), 128'(0));
      check_val("err_busy", 128'(busy_o[0]), 128'(0));
      if (n == 2) begin
        @(posedge clk); #1;
        rd_i[0] = 1'b0; wr_i[0] = 1'b0;
      end
    end
    do_op(0, 1'b0, 16'h0040, 128'h0, 3, 1'b0, "err_rd", r);
    check_val("err_mem_kept", r, la);

    // Inputs changed and request dropped mid-write
    do_op(0, 1'b1, 16'h0080, ld, 3, 1'b1, "pert_wr", r);
    do_op(0, 1'b0, 16'h0080, 128'h0, 3, 1'b0, "pert_rd", r);
    check_val("pert_data", r, ld);

    // Reset after write beat 1
    do_op(0, 1'b1, 16'h00C0, l_old, 3, 1'b0, "old_wr", r);
    @(posedge clk); #1;
    wr_i[0] = 1'b1; addr_i[0] = 16'h00C0; wd_i[0] = l_new;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1; wr_i[0] = 1'b0;
    #1;
    check_val("abort_resp", 128'(resp_o[0]), 128'(0));
    check_val("abort_rdata", rdata_o[0], 128'h0);
    check_val("abort_busy", 128'(busy_o[0]), 128'(0));
    repeat (2) begin
      @(negedge clk);
      check_val("abort_no_resp", 128'(resp_o[0]), 128'(0));
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      check_val("post_rst_idle", 128'(resp_o[0]), 128'(0));
    end
    do_op(0, 1'b0, 16'h00C0, 128'h0, 3, 1'b0, "abort_rd", r);
    check_val("abort_mix_data", r, exp_mix);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
